// File: rtl/apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_pkg : shared types, widths and register map for the APB bridge  |
// | Rev 1.0                                                             |
// +----------------------------------------------------------------------+
package apb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        RDWAIT = 3'd3,
        RESP   = 3'd4
    } apb_state_e;

    // Register-file completer map
    localparam logic [APB_AW-1:0] ADDR_CNTRL = 32'h0000_0000;
    localparam logic [APB_AW-1:0] ADDR_REG1  = 32'h0000_0004;
    localparam logic [APB_AW-1:0] ADDR_REG2  = 32'h0000_0008;
    localparam logic [APB_AW-1:0] ADDR_REG3  = 32'h0000_000C;
    localparam logic [APB_AW-1:0] ADDR_REG4  = 32'h0000_0010;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_master_bridge_if : cmd/rsp channels plus APB3 bus of the bridge |
// | Rev 1.0                                                             |
// +----------------------------------------------------------------------+
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int AW = APB_AW,
    parameter int DW = APB_DW
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    // Bridge view
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    // Requester + completer view
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );

endinterface
`default_nettype wire

// File: rtl/apb_timeout_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_timeout_ctr : saturating stall counter, flags the final stall   |
// | Rev 1.0                                                             |
// +----------------------------------------------------------------------+
module apb_timeout_ctr #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            localparam int              c_CW   = $clog2(TIMEOUT_CYC + 1);
            localparam logic [c_CW-1:0] c_MAX  = c_CW'(TIMEOUT_CYC);
            localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT_CYC - 1);

            logic [c_CW-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    r_cnt <= '0;
                end else if (inc && (r_cnt != c_MAX)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            // Asserted during the TIMEOUT_CYC-th consecutive stall so the abort lands on that edge
            assign expired = inc && (r_cnt >= c_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_master_bridge : cmd/rsp to APB3 requester, one transfer at once |
// | Rev 1.0                                                             |
// +----------------------------------------------------------------------+
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int AW          = APB_AW,
    parameter int DW          = APB_DW,
    parameter int RDATA_LAT   = 1,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                pclk,
    input  logic                presetn,
    apb_master_bridge_if.master bus
);

    apb_state_e    r_state;
    apb_state_e    w_state_nxt;
    logic [AW-1:0] r_paddr,     w_paddr_nxt;
    logic [DW-1:0] r_pwdata,    w_pwdata_nxt;
    logic          r_pwrite,    w_pwrite_nxt;
    logic          r_psel,      w_psel_nxt;
    logic          r_penable,   w_penable_nxt;
    logic          r_rsp_valid, w_rsp_valid_nxt;
    logic          r_rsp_err,   w_rsp_err_nxt;
    logic [DW-1:0] r_rsp_rdata, w_rsp_rdata_nxt;

    logic w_rst;
    logic w_clr;
    logic w_inc;
    logic w_expired;

    assign w_rst = ~presetn;
    assign w_clr = (r_state == IDLE) && bus.cmd_valid && is_word_aligned(bus.cmd_addr[1:0]);
    assign w_inc = (r_state == ACCESS) && !bus.pready;

    apb_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_ctr (
        .clk     (pclk),
        .rst     (w_rst),
        .clr     (w_clr),
        .inc     (w_inc),
        .expired (w_expired)
    );

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state     <= IDLE;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_pwrite_nxt    = r_pwrite;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_rdata_nxt = r_rsp_rdata;

        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    w_paddr_nxt  = bus.cmd_addr;
                    w_pwdata_nxt = bus.cmd_wdata;
                    w_pwrite_nxt = bus.cmd_write;
                    if (!is_word_aligned(bus.cmd_addr[1:0])) begin
                        w_state_nxt     = RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end else begin
                        w_state_nxt   = SETUP;
                        w_psel_nxt    = 1'b1;
                        w_penable_nxt = 1'b0;
                    end
                end
            end

            SETUP: begin
                w_state_nxt   = ACCESS;
                w_penable_nxt = 1'b1;
            end

            ACCESS: begin
                if (bus.pready) begin
                    w_psel_nxt    = 1'b0;
                    w_penable_nxt = 1'b0;
                    w_rsp_err_nxt = bus.pslverr;
                    if (r_pwrite || (RDATA_LAT == 0)) begin
                        w_state_nxt     = RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_rdata_nxt = (r_pwrite || bus.pslverr) ? '0 : bus.prdata;
                    end else begin
                        // pslverr is parked in rsp_err until the late read data arrives
                        w_state_nxt = RDWAIT;
                    end
                end else if (w_expired) begin
                    w_state_nxt     = RESP;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end
            end

            RDWAIT: begin
                w_state_nxt     = RESP;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_rdata_nxt = r_rsp_err ? '0 : bus.prdata;
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_err_nxt   = 1'b0;
                end
            end

            default: begin
                w_state_nxt   = IDLE;
                w_psel_nxt    = 1'b0;
                w_penable_nxt = 1'b0;
            end
        endcase
    end

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.pwrite    = r_pwrite;
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_apb_master_bridge : directed bench with a register-file completer|
// | Rev 1.0                                                             |
// +----------------------------------------------------------------------+
module tb_apb_master_bridge;
    import apb_pkg::*;

    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    always #5 pclk = ~pclk;

    apb_master_bridge_if #(.AW(32), .DW(32)) bus();

    apb_master_bridge #(
        .AW          (32),
        .DW          (32),
        .RDATA_LAT   (1),
        .TIMEOUT_CYC (4)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Register-file completer: CNTRL is 4 bits wide, read data one cycle after completion
    logic        stall      = 1'b0;
    logic        slverr_inj = 1'b0;
    logic [3:0]  rf_cntrl   = '0;
    logic [31:0] rf_reg1    = '0;
    logic [31:0] rf_reg2    = '0;
    logic [31:0] rf_reg3    = '0;
    logic [31:0] rf_reg4    = '0;
    logic [31:0] prdata_q   = '0;

    assign bus.pready  = ~stall;
    assign bus.pslverr = slverr_inj;
    assign bus.prdata  = prdata_q;

    always @(posedge pclk) begin
        if (bus.psel && bus.penable && bus.pready) begin
            if (bus.pwrite) begin
                case (bus.paddr)
                    ADDR_CNTRL: rf_cntrl <= bus.pwdata[3:0];
                    ADDR_REG1:  rf_reg1  <= bus.pwdata;
                    ADDR_REG2:  rf_reg2  <= bus.pwdata;
                    ADDR_REG3:  rf_reg3  <= bus.pwdata;
                    ADDR_REG4:  rf_reg4  <= bus.pwdata;
                    default: ;
                endcase
            end else begin
                case (bus.paddr)
                    ADDR_CNTRL: prdata_q <= {28'd0, rf_cntrl};
                    ADDR_REG1:  prdata_q <= rf_reg1;
                    ADDR_REG2:  prdata_q <= rf_reg2;
                    ADDR_REG3:  prdata_q <= rf_reg3;
                    ADDR_REG4:  prdata_q <= rf_reg4;
                    default:    prdata_q <= '0;
                endcase
            end
        end
    end

    int psel_cyc = 0;
    int pen_cyc  = 0;
    int rspv_cyc = 0;
    always @(posedge pclk) begin
        if (bus.psel === 1'b1)      psel_cyc <= psel_cyc + 1;
        if (bus.penable === 1'b1)   pen_cyc  <= pen_cyc + 1;
        if (bus.rsp_valid === 1'b1) rspv_cyc <= rspv_cyc + 1;
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = data;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_tests++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_wait: got %b want 1", bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_tests++;
        if (bus.rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_wait: rsp_valid got %b want 1 within 40 cycles", bus.rsp_valid);
        end
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int ps, output int pe);
        int p0, e0;
        p0 = psel_cyc;
        e0 = pen_cyc;
        send_cmd(wr, addr, data);
        wait_rsp(lat);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        tick();
        ps = psel_cyc - p0;
        pe = pen_cyc - e0;
    endtask

    task automatic test_reset();
        presetn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        presetn = 1'b1;
        n_tests++; if (bus.psel !== 1'b0)       begin n_fail++; $display("FAIL reset_psel: got %b want 0", bus.psel); end
        n_tests++; if (bus.penable !== 1'b0)    begin n_fail++; $display("FAIL reset_penable: got %b want 0", bus.penable); end
        n_tests++; if (bus.rsp_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_tests++; if (bus.rsp_err !== 1'b0)    begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
        n_tests++; if (bus.paddr !== 32'h0)     begin n_fail++; $display("FAIL reset_paddr: got %h want 0", bus.paddr); end
        n_tests++; if (bus.pwdata !== 32'h0)    begin n_fail++; $display("FAIL reset_pwdata: got %h want 0", bus.pwdata); end
        n_tests++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        n_tests++; if (bus.cmd_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        tick();
        n_tests++; if (bus.cmd_ready !== 1'b1)  begin n_fail++; $display("FAIL idle_cmd_ready: got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        logic        err;
        int          lat, ps, pe;
        xfer(1'b1, ADDR_REG1, 32'hDEADBEEF, rd, err, lat, ps, pe);
        n_tests++; if (err !== 1'b0)      begin n_fail++; $display("FAIL wr_err: got %b want 0", err); end
        n_tests++; if (lat != 3)          begin n_fail++; $display("FAIL wr_latency: got %0d want 3", lat); end
        n_tests++; if (ps != 2)           begin n_fail++; $display("FAIL wr_psel_cycles: got %0d want 2", ps); end
        n_tests++; if (pe != 1)           begin n_fail++; $display("FAIL wr_penable_cycles: got %0d want 1", pe); end
        n_tests++; if (rd !== 32'h0)      begin n_fail++; $display("FAIL wr_rdata: got %h want 0", rd); end
        n_tests++; if (bus.paddr !== 32'h4) begin n_fail++; $display("FAIL wr_paddr_hold: got %h want 4", bus.paddr); end
        n_tests++; if (bus.pwrite !== 1'b1) begin n_fail++; $display("FAIL wr_pwrite_hold: got %b want 1", bus.pwrite); end
        xfer(1'b0, ADDR_REG1, 32'h0, rd, err, lat, ps, pe);
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_reg1: got %h want deadbeef", rd); end
        n_tests++; if (err !== 1'b0)      begin n_fail++; $display("FAIL rd_err: got %b want 0", err); end
        n_tests++; if (lat != 4)          begin n_fail++; $display("FAIL rd_latency: got %0d want 4", lat); end
        n_tests++; if (ps != 2)           begin n_fail++; $display("FAIL rd_psel_cycles: got %0d want 2", ps); end
        n_tests++; if (pe != 1)           begin n_fail++; $display("FAIL rd_penable_cycles: got %0d want 1", pe); end
        n_tests++; if (bus.pwrite !== 1'b0) begin n_fail++; $display("FAIL rd_pwrite_hold: got %b want 0", bus.pwrite); end
    endtask

    task automatic test_regmap();
        logic [31:0] rd;
        logic        err;
        int          lat, ps, pe;
        xfer(1'b1, ADDR_CNTRL, 32'hFFFFFFFF, rd, err, lat, ps, pe);
        xfer(1'b0, ADDR_CNTRL, 32'h0, rd, err, lat, ps, pe);
        n_tests++; if (rd !== 32'h0000000F) begin n_fail++; $display("FAIL rd_cntrl: got %h want 0000000f", rd); end
        xfer(1'b0, 32'h14, 32'h0, rd, err, lat, ps, pe);
        n_tests++; if (rd !== 32'h0)      begin n_fail++; $display("FAIL rd_unmapped: got %h want 0", rd); end
        n_tests++; if (err !== 1'b0)      begin n_fail++; $display("FAIL rd_unmapped_err: got %b want 0", err); end
        xfer(1'b1, ADDR_REG4, 32'h12345678, rd, err, lat, ps, pe);
        xfer(1'b0, ADDR_REG4, 32'h0, rd, err, lat, ps, pe);
        n_tests++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL rd_reg4: got %h want 12345678", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd;
        logic        err;
        int          lat, ps, pe;
        xfer(1'b0, 32'h6, 32'h0, rd, err, lat, ps, pe);
        n_tests++; if (ps != 0)           begin n_fail++; $display("FAIL mis_psel_cycles: got %0d want 0", ps); end
        n_tests++; if (lat != 1)          begin n_fail++; $display("FAIL mis_latency: got %0d want 1", lat); end
        n_tests++; if (err !== 1'b1)      begin n_fail++; $display("FAIL mis_err: got %b want 1", err); end
        n_tests++; if (rd !== 32'h0)      begin n_fail++; $display("FAIL mis_rdata: got %h want 0", rd); end
        n_tests++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL mis_err_clear: got %b want 0", bus.rsp_err); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        err;
        int          lat, ps, pe;
        xfer(1'b0, ADDR_REG1, 32'h0, rd, err, lat, ps, pe);
        stall = 1'b1;
        xfer(1'b0, ADDR_REG2, 32'h0, rd, err, lat, ps, pe);
        stall = 1'b0;
        n_tests++; if (err !== 1'b1)      begin n_fail++; $display("FAIL to_err: got %b want 1", err); end
        n_tests++; if (rd !== 32'h0)      begin n_fail++; $display("FAIL to_rdata: got %h want 0", rd); end
        n_tests++; if (lat != 6)          begin n_fail++; $display("FAIL to_latency: got %0d want 6", lat); end
        n_tests++; if (ps != 5)           begin n_fail++; $display("FAIL to_psel_cycles: got %0d want 5", ps); end
        n_tests++; if (pe != 4)           begin n_fail++; $display("FAIL to_penable_cycles: got %0d want 4", pe); end
        slverr_inj = 1'b1;
        xfer(1'b1, ADDR_REG3, 32'hA5A5A5A5, rd, err, lat, ps, pe);
        n_tests++; if (err !== 1'b1)      begin n_fail++; $display("FAIL slv_wr_err: got %b want 1", err); end
        n_tests++; if (lat != 3)          begin n_fail++; $display("FAIL slv_wr_latency: got %0d want 3", lat); end
        xfer(1'b0, ADDR_REG1, 32'h0, rd, err, lat, ps, pe);
        n_tests++; if (err !== 1'b1)      begin n_fail++; $display("FAIL slv_rd_err: got %b want 1", err); end
        n_tests++; if (rd !== 32'h0)      begin n_fail++; $display("FAIL slv_rd_rdata: got %h want 0", rd); end
        slverr_inj = 1'b0;
        xfer(1'b0, ADDR_REG1, 32'h0, rd, err, lat, ps, pe);
        n_tests++; if (err !== 1'b0)      begin n_fail++; $display("FAIL post_err_clean: got %b want 0", err); end
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL post_err_rdata: got %h want deadbeef", rd); end
    endtask

    task automatic test_backpressure();
        int lat;
        bus.rsp_ready = 1'b0;
        send_cmd(1'b0, ADDR_REG1, 32'h0);
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.rsp_valid); end
            n_tests++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bp_rdata[%0d]: got %h want deadbeef", i, bus.rsp_rdata); end
            n_tests++; if (bus.rsp_err !== 1'b0)   begin n_fail++; $display("FAIL bp_err[%0d]: got %b want 0", i, bus.rsp_err); end
            n_tests++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_cmd_ready[%0d]: got %b want 0", i, bus.cmd_ready); end
        end
        bus.rsp_ready = 1'b1;
        tick();
        n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", bus.rsp_valid); end
        n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_cmd_ready: got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_reset_mid();
        int          r0;
        logic [31:0] rd;
        logic        err;
        int          lat, ps, pe;
        stall = 1'b1;
        r0    = rspv_cyc;
        send_cmd(1'b0, ADDR_REG1, 32'h0);
        tick();
        n_tests++; if (bus.penable !== 1'b1) begin n_fail++; $display("FAIL mid_in_access: penable got %b want 1", bus.penable); end
        presetn = 1'b0;
        tick();
        n_tests++; if (bus.psel !== 1'b0)      begin n_fail++; $display("FAIL mid_psel: got %b want 0", bus.psel); end
        n_tests++; if (bus.penable !== 1'b0)   begin n_fail++; $display("FAIL mid_penable: got %b want 0", bus.penable); end
        n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid: got %b want 0", bus.rsp_valid); end
        presetn = 1'b1;
        stall   = 1'b0;
        repeat (6) tick();
        n_tests++; if (rspv_cyc - r0 != 0)     begin n_fail++; $display("FAIL mid_no_rsp: got %0d rsp cycles want 0", rspv_cyc - r0); end
        n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_cmd_ready: got %b want 1", bus.cmd_ready); end
        xfer(1'b0, ADDR_REG1, 32'h0, rd, err, lat, ps, pe);
        n_tests++; if (rd !== 32'hDEADBEEF)    begin n_fail++; $display("FAIL mid_recover_rdata: got %h want deadbeef", rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_regmap();
        test_misaligned();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
`default_nettype wire
